rst_sync: RTL and testbench



---
 rtl/rst_sync_pkg.sv | 14 +
 rtl/rst_sync.sv | 46 ++++
 tb/tb_rst_sync.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rst_sync_pkg.sv
// -----------------------------------------------------------------------------
// rst_sync_pkg
// Purpose : constants shared by the reset synchronizer. They give the legal
//           range for the depth of the synchronizing flop chain.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package rst_sync_pkg;

  // Fewer than two flops gives no metastability settling time. More than
  // eight only adds release latency without any practical benefit.
  localparam int unsigned RST_SYNC_MIN_STAGES = 32'd2;
  localparam int unsigned RST_SYNC_MAX_STAGES = 32'd8;

endpackage : rst_sync_pkg

// File: rtl/rst_sync.sv
// -----------------------------------------------------------------------------
// rst_sync
// Purpose : Reset synchronizer for one clock domain. RST is sampled on every
//           rising edge of CLK. Any edge that samples RST=0 clears the whole
//           chain at once, so SYNC_RST asserts after one edge. Each edge that
//           samples RST=1 shifts a 1 into the chain. SYNC_RST releases after
//           NUM_STAGES consecutive such edges.
// Ports   : CLK      in  1  domain clock, rising-edge active
//           RST      in  1  reset request, active-low, sampled on CLK
//           SYNC_RST out 1  synchronized reset, active-low, driven directly
//                           by the last chain flop
// Params  : NUM_STAGES  chain depth, legal range 2..8
// -----------------------------------------------------------------------------
module rst_sync
  import rst_sync_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 32'd2
) (
  input  logic CLK,
  input  logic RST,
  output logic SYNC_RST
);

  // Stop elaboration on an out-of-range chain depth.
  if ((NUM_STAGES < RST_SYNC_MIN_STAGES) || (NUM_STAGES > RST_SYNC_MAX_STAGES)) begin : g_bad_num_stages
    $error("rst_sync: NUM_STAGES=%0d is outside the legal range %0d..%0d",
           NUM_STAGES, RST_SYNC_MIN_STAGES, RST_SYNC_MAX_STAGES);
  end

  // r_stage[0] is the first flop and r_stage[NUM_STAGES-1] drives SYNC_RST.
  logic [NUM_STAGES-1:0] r_stage;

  // Synchronizing chain. A sampled low clears every stage, which restarts
  // the release count from zero. A sampled high shifts a 1 in at stage 0.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[NUM_STAGES-2:0], 1'b1};
    end
  end

  // Output comes straight from a flop, so it can only change on CLK edges.
  assign SYNC_RST = r_stage[NUM_STAGES-1];

endmodule : rst_sync

// File: tb/tb_rst_sync.sv
// -----------------------------------------------------------------------------
// tb_rst_sync
// Purpose : self-checking bench for rst_sync. It runs three instances
//           (NUM_STAGES = 2, 3, 8) in parallel from one shared CLK and RST.
//           A reference model counts consecutive RST=1 samples: SYNC_RST
//           must be 1 exactly when that count has reached NUM_STAGES. It
//           must be 0 otherwise, once a reset has been captured.
// -----------------------------------------------------------------------------
module tb_rst_sync;

  logic       CLK;
  logic       RST;
  logic [2:0] sync;

  int checks   = 0;
  int failures = 0;

  // chain depth of each instance, indexed like sync[]
  int nstg [3] = '{2, 3, 8};

  // reference model state
  int cnt  = 0;   // consecutive edges that sampled RST=1
  bit seen = 1'b0; // at least one reset captured

  rst_sync #(.NUM_STAGES(32'd2)) u_dut2 (.CLK(CLK), .RST(RST), .SYNC_RST(sync[0]));
  rst_sync #(.NUM_STAGES(32'd3)) u_dut3 (.CLK(CLK), .RST(RST), .SYNC_RST(sync[1]));
  rst_sync #(.NUM_STAGES(32'd8)) u_dut8 (.CLK(CLK), .RST(RST), .SYNC_RST(sync[2]));

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // reference model: count RST=1 samples, restart on a sampled low
  always @(posedge CLK) begin
    if (RST == 1'b0) begin
      cnt  <= 0;
      seen <= 1'b1;
    end else if (cnt < 1000) begin
      cnt <= cnt + 1;
    end
  end

  // Power-up with no reset, plus a low pulse (t=7..13) that spans no edge
  task automatic test_powerup();
    logic exp;
    #7 RST = 1'b0;
    #6 RST = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      for (int k = 0; k < 3; k++) begin
        // before any capture, output is only defined once the chain is full
        if (seen || (cnt >= nstg[k])) begin
          exp = (cnt >= nstg[k]) ? 1'b1 : 1'b0;
          checks++;
          if (sync[k] !== exp) begin
            failures++;
            $display("FAIL powerup N=%0d t=%0t: SYNC_RST=%b expected %b", nstg[k], $time, sync[k], exp);
          end
        end
      end
    end
  endtask

  // Captured reset asserts in one edge; release takes exactly N edges
  task automatic test_reset();
    logic exp;
    RST = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (sync[k] !== 1'b0) begin
          failures++;
          $display("FAIL reset_assert N=%0d t=%0t: SYNC_RST=%b expected 0", nstg[k], $time, sync[k]);
        end
      end
    end
    RST = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(negedge CLK);
      for (int k = 0; k < 3; k++) begin
        exp = (e >= nstg[k]) ? 1'b1 : 1'b0;
        checks++;
        if (sync[k] !== exp) begin
          failures++;
          $display("FAIL release edge=%0d N=%0d: SYNC_RST=%b expected %b", e, nstg[k], sync[k], exp);
        end
      end
    end
  endtask

  // Reset arriving after one release edge restarts the count from zero
  task automatic test_mid_release();
    logic exp;
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sync[k] !== 1'b0) begin
        failures++;
        $display("FAIL mid_release_assert N=%0d: SYNC_RST=%b expected 0", nstg[k], sync[k]);
      end
    end
    RST = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(negedge CLK);
      for (int k = 0; k < 3; k++) begin
        exp = (e >= nstg[k]) ? 1'b1 : 1'b0;
        checks++;
        if (sync[k] !== exp) begin
          failures++;
          $display("FAIL mid_release edge=%0d N=%0d: SYNC_RST=%b expected %b", e, nstg[k], sync[k], exp);
        end
      end
    end
  endtask

  // Fully released, then one sampled low: immediate assert, full re-release
  task automatic test_reset_while_released();
    logic exp;
    RST = 1'b0;
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sync[k] !== 1'b0) begin
        failures++;
        $display("FAIL released_assert N=%0d: SYNC_RST=%b expected 0", nstg[k], sync[k]);
      end
    end
    RST = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(negedge CLK);
      for (int k = 0; k < 3; k++) begin
        exp = (e >= nstg[k]) ? 1'b1 : 1'b0;
        checks++;
        if (sync[k] !== exp) begin
          failures++;
          $display("FAIL released_rerelease edge=%0d N=%0d: SYNC_RST=%b expected %b", e, nstg[k], sync[k], exp);
        end
      end
    end
  endtask

  // Low pulses between edges must not disturb a released chain
  task automatic test_short_pulse();
    repeat (5) begin
      @(negedge CLK);
      #1 RST = 1'b0;
      #2 RST = 1'b1;
      @(negedge CLK);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (sync[k] !== 1'b1) begin
          failures++;
          $display("FAIL short_pulse N=%0d t=%0t: SYNC_RST=%b expected 1", nstg[k], $time, sync[k]);
        end
      end
    end
  endtask

  // Random RST pattern with occasional uncaptured glitches, model-checked
  task automatic test_random();
    logic exp;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      for (int k = 0; k < 3; k++) begin
        exp = (cnt >= nstg[k]) ? 1'b1 : 1'b0;
        checks++;
        if (sync[k] !== exp) begin
          failures++;
          $display("FAIL random cyc=%0d N=%0d: SYNC_RST=%b expected %b (ones=%0d)", c, nstg[k], sync[k], exp, cnt);
        end
      end
      RST = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
      if ((RST == 1'b1) && ($urandom_range(0, 9) == 0)) begin
        #1 RST = 1'b0;
        #2 RST = 1'b1;
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    test_powerup();
    test_reset();
    test_mid_release();
    test_reset_while_released();
    test_short_pulse();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rst_sync
